// File: rtl/parity_frame_ctrl_if.sv
// Word handshake and serial-line bundle for parity_frame_ctrl.
// master: drives in_valid/in_data/odd_sel; slave: drives in_ready/tx_out/busy/frame_done.
interface parity_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              odd_sel;
    logic              in_ready;
    logic              tx_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output in_valid,
        output in_data,
        output odd_sel,
        input  in_ready,
        input  tx_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  odd_sel,
        output in_ready,
        output tx_out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Serial framer: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Ports: clk, reset (sync, active-high), bus (slave side of parity_frame_ctrl_if).
module parity_frame_ctrl #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    parity_frame_ctrl_if.slave  bus
);
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  cyc_cnt_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_nxt;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic              tx_q;
    logic              done_q;
    logic              tx_nxt;
    logic              done_nxt;
    logic              accept;
    logic              last_cyc;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_cyc = (cyc_cnt == CNT_LAST);

    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = cyc_cnt;
        bit_idx_nxt = bit_idx;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt   = START;
                    cyc_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                end
            end
            START: begin
                if (last_cyc) begin
                    state_nxt   = DATA;
                    cyc_cnt_nxt = '0;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    cyc_cnt_nxt = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt   = PARITY;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (last_cyc) begin
                    state_nxt   = STOP;
                    cyc_cnt_nxt = '0;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_nxt   = IDLE;
                    cyc_cnt_nxt = '0;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cyc_cnt_nxt = '0;
                bit_idx_nxt = '0;
            end
        endcase
    end

    // Line level and done pulse are computed from the next state so that
    // the registered outputs line up with the state they describe.
    always_comb begin
        tx_nxt   = 1'b1;
        done_nxt = 1'b0;
        unique case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[bit_idx_nxt];
            PARITY:  tx_nxt = par_q;
            STOP: begin
                tx_nxt   = 1'b1;
                done_nxt = (cyc_cnt_nxt == CNT_LAST);
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            tx_q    <= tx_nxt;
            done_q  <= done_nxt;
        end
    end

    // Word and parity are frozen at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (accept) begin
            data_q <= bus.in_data;
            par_q  <= (^bus.in_data) ^ bus.odd_sel;
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.tx_out     = tx_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Randomized bench for parity_frame_ctrl against a queue-of-line-bits model.
// Ports exercised: clk, reset and every signal of parity_frame_ctrl_if.
module tb_parity_frame_ctrl;
    localparam int DW = 8;
    localparam int BC = 4;
    localparam int FLEN = (DW + 3) * BC;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   acc_cnt;
    bit   exp_q[$];

    parity_frame_ctrl_if #(.DATA_W(DW)) bus ();

    parity_frame_ctrl #(
        .DATA_W(DW),
        .BIT_CYCLES(BC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line: start bit, data LSB first, parity, stop, each BC cycles.
    task automatic push_frame(input logic [DW-1:0] d, input logic o);
        bit par;
        par = bit'(($countones(d) % 2) != 0) ^ o;
        for (int k = 0; k < BC; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++)
            for (int k = 0; k < BC; k++) exp_q.push_back(d[i]);
        for (int k = 0; k < BC; k++) exp_q.push_back(par);
        for (int k = 0; k < BC; k++) exp_q.push_back(1'b1);
    endtask

    // One clock: check outputs at negedge, apply inputs, advance the model.
    task automatic cyc(input logic v, input logic [DW-1:0] d,
                       input logic o, input logic r);
        bit idle;
        @(negedge clk);
        idle = (exp_q.size() == 0);
        acc_cnt++;
        chk("tx_out", int'(bus.tx_out), idle ? 1 : int'(exp_q[0]));
        chk("in_ready", int'(bus.in_ready), int'(idle));
        chk("busy", int'(bus.busy), int'(!idle));
        chk("frame_done", int'(bus.frame_done), int'(exp_q.size() == 1));
        if (bus.frame_done === 1'b1) chk("frame_len", acc_cnt, FLEN);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.odd_sel  = o;
        reset        = r;
        if (r) begin
            exp_q.delete();
        end else if (!idle) begin
            void'(exp_q.pop_front());
        end else if (v) begin
            push_frame(d, o);
            acc_cnt = 0;
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, DW'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        acc_cnt      = 1000;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.odd_sel  = 1'b0;

        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h5A, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        idle_n(2);

        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        idle_n(FLEN + 3);
        cyc(1'b1, 8'h07, 1'b0, 1'b0);
        idle_n(FLEN + 3);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        idle_n(FLEN + 3);

        cyc(1'b1, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < FLEN - 1; i++)
            cyc(1'($urandom), DW'($urandom), 1'($urandom), 1'b0);
        idle_n(4);

        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < FLEN + 1 + FLEN + 2; i++)
            cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        idle_n(FLEN + 3);

        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        idle_n(BC + 2 * BC + 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);
        idle_n(FLEN + 3);

        cyc(1'b1, 8'h81, 1'b0, 1'b1);
        cyc(1'b1, 8'h42, 1'b1, 1'b0);
        idle_n(FLEN + 3);

        for (int i = 0; i < 4000; i++)
            cyc(($urandom % 4) != 0, DW'($urandom), 1'($urandom),
                ($urandom % 300) == 0);
        idle_n(FLEN + 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of each data word, legal range 1..16.
REQ-002 Parameter BIT_CYCLES, default 4: clock cycles per serial bit, legal range 1..255.
REQ-003 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: requester presents a word.
REQ-007 Port in_data, input, DATA_W bits: word to frame.
REQ-008 Port odd_sel, input, 1 bit: 0 selects even parity, 1 selects odd parity; sampled at accept.
REQ-009 Port in_ready, output, 1 bit: controller can accept a word.
REQ-010 Port tx_out, output, 1 bit: registered serial line.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, START, DATA, PARITY and STOP.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL equal NOT in_ready.
REQ-015 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; on that edge in_data and odd_sel are captured and the state moves to START.
REQ-016 A word presented while busy=1 SHALL be ignored, with no capture and no stall of the current frame.
REQ-017 The captured parity bit SHALL equal the XOR of all DATA_W data bits, inverted when the captured odd_sel=1.
REQ-018 Effect of REQ-017: the total count of ones over data plus parity is even for odd_sel=0 and odd for odd_sel=1.
REQ-019 tx_out SHALL be 1 in IDLE.
REQ-020 tx_out SHALL be 0 for BIT_CYCLES cycles in START.
REQ-021 In DATA, tx_out SHALL carry captured bits LSB first, each held for BIT_CYCLES cycles.
REQ-022 tx_out SHALL carry the parity bit for BIT_CYCLES cycles in PARITY.
REQ-023 tx_out SHALL be 1 for BIT_CYCLES cycles in STOP.
REQ-024 Latency: the first START cycle of tx_out SHALL be the cycle after the accept edge.
REQ-025 The frame SHALL occupy exactly (DATA_W+3)*BIT_CYCLES cycles from START through STOP.
REQ-026 Counting SHALL use a cycle counter (0..BIT_CYCLES-1) and a bit index (0..DATA_W-1); both wrap to 0 on each bit or state change.
REQ-027 No counter SHALL overflow at the parameter maxima.
REQ-028 frame_done SHALL be 1 exactly in the last STOP cycle.
REQ-029 The next state after STOP SHALL be IDLE, so there is at least one IDLE cycle between frames.
REQ-030 With in_valid held high, back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-031 Changes on in_data or odd_sel after accept SHALL NOT affect the frame in progress.

Reset
REQ-032 While reset=1, the state SHALL be IDLE, tx_out=1, in_ready=1, busy=0 and frame_done=0, with the counters and capture register cleared.
REQ-033 Reset during any state SHALL abort the frame at the next edge; the aborted word is never resumed or re-sent.
REQ-034 reset SHALL take priority over a simultaneous accept; no word is captured on that edge.
REQ-035 An accept on the first cycle after reset deasserts SHALL be honoured.

Verification
REQ-036 Even parity: DATA_W=8, BIT_CYCLES=4, in_data=0x00, odd_sel=0 -> tx_out sequence 0, 0x00 bits, parity 0, then 1; 44 cycles; frame_done on cycle 44.
REQ-037 Even parity, odd ones: in_data=0x07, odd_sel=0 -> data bits 1,1,1,0,0,0,0,0, parity bit 1.
REQ-038 Odd parity: in_data=0xFF, odd_sel=1 -> parity bit 1.
REQ-039 Ignored request: in_data=0x01, odd_sel=1 -> parity 0; changing in_data and odd_sel mid-frame and pulsing in_valid while busy -> frame unchanged and no extra accept.
REQ-040 Back-to-back: in_valid held high with 0xA5 then 0x3C -> two complete frames separated by one IDLE cycle with tx_out=1; parities 0 and 0 (even).
REQ-041 Reset mid-frame: reset for one cycle during the DATA state -> next cycle tx_out=1 and in_ready=1; the following accept produces a clean full frame.
